fifo_sync_mc: RTL and testbench

//  Single-clock, multi-channel synchronous FIFO for buffering feature-map/weight words between CNN stages.
//  NUM_CH lanes share one set of pointers, so the lanes push and pop in lockstep.

---
 rtl/fifo_sync_mc.sv | 189 ++++++++++++++++++
 tb/tb_fifo_sync_mc.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_mc.sv
// Purpose : single-clock multi-lane FIFO; NUM_CH lanes share pointers and push/pop in lockstep.
// Latency : registered read, data_out/rd_valid one clk after an accepted pop; no write-through.
// Backpr. : no stall path; pushes into full and pops from empty are dropped, full/empty tell the producer/consumer.
//
// Optional feature macro: FIFO_ERR_FLAGS_EN adds sticky ovf_err/udf_err outputs.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   clr       synchronous flush (pointers, count, read output to zero); wins over wr_en/rd_en
//   wr_en     push request
//   rd_en     pop request
//   rd_hold   with rd_en: read the head entry without consuming it (replay)
//   data_in   NUM_CH*DATA_WIDTH write lanes, ch0 in the LSBs
//   data_out  NUM_CH*DATA_WIDTH registered read lanes, zero when no read happened
//   rd_valid  data_out carries a word read in the previous cycle
//   full      count == FIFO_DEPTH
//   empty     count == 0
//   count     number of stored entries (ADD_WIDTH+1 bits)
//   ovf_err   (FIFO_ERR_FLAGS_EN) sticky: a push was refused
//   udf_err   (FIFO_ERR_FLAGS_EN) sticky: a pop was attempted on an empty FIFO

module fifo_sync_mc #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 10,
    parameter int ADD_WIDTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         wr_en,
    input  logic                         rd_en,
    input  logic                         rd_hold,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
    output logic                         rd_valid,
    output logic                         full,
    output logic                         empty,
    output logic [ADD_WIDTH:0]           count
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                         ovf_err,
    output logic                         udf_err
`endif
);

    localparam int                    WORD_W    = NUM_CH * DATA_WIDTH;
    localparam logic [ADD_WIDTH-1:0]  LAST_PTR  = ADD_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [ADD_WIDTH:0]    DEPTH_CNT = (ADD_WIDTH + 1)'(FIFO_DEPTH);

    // Pointers wrap at FIFO_DEPTH-1 rather than at a power of two, so the
    // depth can be any value >= 2.
    function automatic logic [ADD_WIDTH-1:0] ptr_inc(input logic [ADD_WIDTH-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    logic [ADD_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADD_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADD_WIDTH:0]   count_q, count_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [WORD_W-1:0]    data_out_q, data_out_d;

    logic                 empty_w;
    logic                 full_w;
    logic                 rd_acc;
    logic                 rd_pop;
    logic                 wr_acc;
    logic                 mem_we;
    logic [WORD_W-1:0]    rd_word;

    // Status is decoded from the registered count only; with a non-power-of-2
    // depth a pointer compare would need an extra wrap bit anyway.
    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == DEPTH_CNT);

    assign rd_acc  = rd_en & ~empty_w;
    // A hold read leaves the head entry in place, so it frees no slot.
    assign rd_pop  = rd_acc & ~rd_hold;
    // A full FIFO can still take a push when a consuming pop frees a slot in
    // the same cycle; a push alongside a pop on an empty FIFO is accepted
    // while the pop is refused (no bypass).
    assign wr_acc  = wr_en & (~full_w | rd_pop);
    assign mem_we  = wr_acc & ~clr;

    // Per-lane storage; memory is deliberately not reset. A read and a write
    // to the same address in one cycle return the old contents because the
    // read is sampled from the array before the write lands.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
        logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

        always_ff @(posedge clk) begin
            if (mem_we) begin
                mem[wr_ptr_q] <= data_in[ch*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        assign rd_word[ch*DATA_WIDTH +: DATA_WIDTH] = mem[rd_ptr_q];
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = 1'b0;
        data_out_d = '0;

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (rd_acc) begin
                rd_valid_d = 1'b1;
                data_out_d = rd_word;
            end
            if (rd_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            // Push and consuming pop together leave the occupancy unchanged.
            if (wr_acc && !rd_pop) begin
                count_d = count_q + 1'b1;
            end else if (!wr_acc && rd_pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign full     = full_w;
    assign empty    = empty_w;

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_err_q, ovf_err_d;
    logic udf_err_q, udf_err_d;

    // Sticky error capture; only rst or clr clears them.
    always_comb begin
        ovf_err_d = ovf_err_q;
        udf_err_d = udf_err_q;
        if (clr) begin
            ovf_err_d = 1'b0;
            udf_err_d = 1'b0;
        end else begin
            if (wr_en && !wr_acc) begin
                ovf_err_d = 1'b1;
            end
            if (rd_en && empty_w) begin
                udf_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_err_q <= 1'b0;
            udf_err_q <= 1'b0;
        end else begin
            ovf_err_q <= ovf_err_d;
            udf_err_q <= udf_err_d;
        end
    end

    assign ovf_err = ovf_err_q;
    assign udf_err = udf_err_q;
`endif

endmodule

// File: tb/tb_fifo_sync_mc.sv
// Purpose : directed self-checking bench for fifo_sync_mc (DEPTH=10, 4 lanes of 16 bits).
// Latency : inputs change 1 time unit after a rising edge; outputs are checked at that same point.
// Backpr. : not applicable; all sequences run a fixed number of cycles.

module tb_fifo_sync_mc;

    localparam int DW    = 16;
    localparam int NCH   = 4;
    localparam int DEPTH = 10;
    localparam int AW    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              clr;
    logic              wr_en;
    logic              rd_en;
    logic              rd_hold;
    logic [NCH*DW-1:0] data_in;
    logic [NCH*DW-1:0] data_out;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic [AW:0]       count;
`ifdef FIFO_ERR_FLAGS_EN
    logic              ovf_err;
    logic              udf_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_sync_mc #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NCH),
        .FIFO_DEPTH (DEPTH),
        .ADD_WIDTH  (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .rd_hold  (rd_hold),
        .data_in  (data_in),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .full     (full),
        .empty    (empty),
        .count    (count)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .ovf_err  (ovf_err),
        .udf_err  (udf_err)
`endif
    );

    // Distinct per-lane content so lane swaps or shifts show up.
    function automatic logic [NCH*DW-1:0] pk(input logic [15:0] v);
        return {v + 16'h3000, v + 16'h2000, v + 16'h1000, v};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        rd_hold = 1'b0;
    endtask

    task automatic test_reset();
        // rst has been high since time 0 and no clock edge has happened yet.
        total++; if (data_out !== '0)  begin bad++; $display("FAIL reset_data_out got=%h want=0", data_out); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b want=0", rd_valid); end
        total++; if (count !== 5'd0)    begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (empty !== 1'b1)    begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
        total++; if (full !== 1'b0)     begin bad++; $display("FAIL reset_full got=%b want=0", full); end
`ifdef FIFO_ERR_FLAGS_EN
        total++; if ({ovf_err, udf_err} !== 2'b00) begin bad++; $display("FAIL reset_err_flags got=%b want=00", {ovf_err, udf_err}); end
`endif
        #2 rst = 1'b0;
        step();
        // Mid-burst: three pushes then a pop in flight.
        for (int i = 1; i <= 3; i++) begin
            wr_en = 1'b1; data_in = pk(16'(i)); step();
        end
        wr_en = 1'b0; rd_en = 1'b1; step();
        total++; if (data_out !== pk(16'd1)) begin bad++; $display("FAIL midrst_pre_data got=%h want=%h", data_out, pk(16'd1)); end
        total++; if (rd_valid !== 1'b1)      begin bad++; $display("FAIL midrst_pre_valid got=%b want=1", rd_valid); end
        // Assert reset between edges and check its effect before the next edge.
        #2 rst = 1'b1;
        #1;
        total++; if (data_out !== '0)   begin bad++; $display("FAIL midrst_data got=%h want=0", data_out); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", rd_valid); end
        total++; if (count !== 5'd0)    begin bad++; $display("FAIL midrst_count got=%0d want=0", count); end
        total++; if (empty !== 1'b1)    begin bad++; $display("FAIL midrst_empty got=%b want=1", empty); end
        rd_en = 1'b0;
        #2 rst = 1'b0;
        step();
        total++; if (count !== 5'd0) begin bad++; $display("FAIL postrst_count got=%0d want=0", count); end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 10; i++) begin
            wr_en = 1'b1; data_in = pk(16'(i)); step();
        end
        total++; if (count !== 5'd10) begin bad++; $display("FAIL fill_count got=%0d want=10", count); end
        total++; if (full !== 1'b1)   begin bad++; $display("FAIL fill_full got=%b want=1", full); end
        total++; if (empty !== 1'b0)  begin bad++; $display("FAIL fill_empty got=%b want=0", empty); end
        data_in = pk(16'd11); step();
        wr_en = 1'b0;
        total++; if (count !== 5'd10) begin bad++; $display("FAIL push_full_count got=%0d want=10", count); end
        for (int i = 1; i <= 10; i++) begin
            rd_en = 1'b1; step();
            total++; if (data_out !== pk(16'(i))) begin bad++; $display("FAIL drain_data[%0d] got=%h want=%h", i, data_out, pk(16'(i))); end
            total++; if (rd_valid !== 1'b1)       begin bad++; $display("FAIL drain_valid[%0d] got=%b want=1", i, rd_valid); end
        end
        rd_en = 1'b0;
        total++; if (empty !== 1'b1)  begin bad++; $display("FAIL drain_empty got=%b want=1", empty); end
        total++; if (count !== 5'd0)  begin bad++; $display("FAIL drain_count got=%0d want=0", count); end
        step();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", rd_valid); end
        total++; if (data_out !== '0)   begin bad++; $display("FAIL idle_data got=%h want=0", data_out); end
        rd_en = 1'b1; step(); rd_en = 1'b0;
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL pop_empty_valid got=%b want=0", rd_valid); end
        total++; if (count !== 5'd0)    begin bad++; $display("FAIL pop_empty_count got=%0d want=0", count); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 7; i++) begin
            wr_en = 1'b1; data_in = pk(16'(16'h20 + i)); step();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            rd_en = 1'b1; step();
            total++; if (data_out !== pk(16'(16'h20 + i))) begin bad++; $display("FAIL wrap_a[%0d] got=%h want=%h", i, data_out, pk(16'(16'h20 + i))); end
        end
        rd_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; data_in = pk(16'(16'h40 + i)); step();
        end
        wr_en = 1'b0;
        total++; if (count !== 5'd8) begin bad++; $display("FAIL wrap_count got=%0d want=8", count); end
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1; step();
            total++; if (data_out !== pk(16'(16'h40 + i))) begin bad++; $display("FAIL wrap_b[%0d] got=%h want=%h", i, data_out, pk(16'(16'h40 + i))); end
        end
        rd_en = 1'b0;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b want=1", empty); end
    endtask

    task automatic test_empty_push_pop();
        wr_en = 1'b1; rd_en = 1'b1; data_in = pk(16'h55); step();
        wr_en = 1'b0;
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL epp_valid got=%b want=0", rd_valid); end
        total++; if (data_out !== '0)   begin bad++; $display("FAIL epp_data got=%h want=0", data_out); end
        total++; if (count !== 5'd1)    begin bad++; $display("FAIL epp_count got=%0d want=1", count); end
        step();
        rd_en = 1'b0;
        total++; if (data_out !== pk(16'h55)) begin bad++; $display("FAIL epp_pop got=%h want=%h", data_out, pk(16'h55)); end
        total++; if (count !== 5'd0)          begin bad++; $display("FAIL epp_pop_count got=%0d want=0", count); end
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; data_in = pk(16'(16'h60 + i)); step();
        end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fs_full got=%b want=1", full); end
        // Hold read frees no slot, so the push must be refused.
        rd_en = 1'b1; rd_hold = 1'b1; data_in = pk(16'hBB); step();
        total++; if (data_out !== pk(16'h60)) begin bad++; $display("FAIL fs_hold_data got=%h want=%h", data_out, pk(16'h60)); end
        total++; if (count !== 5'd10)         begin bad++; $display("FAIL fs_hold_count got=%0d want=10", count); end
        rd_hold = 1'b0; data_in = pk(16'hAA); step();
        wr_en = 1'b0;
        total++; if (data_out !== pk(16'h60)) begin bad++; $display("FAIL fs_simul_data got=%h want=%h", data_out, pk(16'h60)); end
        total++; if (count !== 5'd10)         begin bad++; $display("FAIL fs_simul_count got=%0d want=10", count); end
        total++; if (full !== 1'b1)           begin bad++; $display("FAIL fs_simul_full got=%b want=1", full); end
        for (int i = 1; i <= 10; i++) begin
            logic [15:0] ev;
            ev = (i < 10) ? 16'(16'h60 + i) : 16'hAA;
            step();
            total++; if (data_out !== pk(ev)) begin bad++; $display("FAIL fs_drain[%0d] got=%h want=%h", i, data_out, pk(ev)); end
        end
        rd_en = 1'b0;
        total++; if (count !== 5'd0) begin bad++; $display("FAIL fs_end_count got=%0d want=0", count); end
    endtask

    task automatic test_replay();
        wr_en = 1'b1; data_in = pk(16'hA1); step();
        data_in = pk(16'hB2); step();
        wr_en = 1'b0;
        rd_en = 1'b1; rd_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (data_out !== pk(16'hA1)) begin bad++; $display("FAIL replay_data[%0d] got=%h want=%h", i, data_out, pk(16'hA1)); end
            total++; if (rd_valid !== 1'b1)       begin bad++; $display("FAIL replay_valid[%0d] got=%b want=1", i, rd_valid); end
            total++; if (count !== 5'd2)          begin bad++; $display("FAIL replay_count[%0d] got=%0d want=2", i, count); end
        end
        rd_hold = 1'b0; step();
        total++; if (data_out !== pk(16'hA1)) begin bad++; $display("FAIL replay_pop_data got=%h want=%h", data_out, pk(16'hA1)); end
        total++; if (count !== 5'd1)          begin bad++; $display("FAIL replay_pop_count got=%0d want=1", count); end
        step();
        rd_en = 1'b0;
        total++; if (data_out !== pk(16'hB2)) begin bad++; $display("FAIL replay_b_data got=%h want=%h", data_out, pk(16'hB2)); end
        total++; if (count !== 5'd0)          begin bad++; $display("FAIL replay_b_count got=%0d want=0", count); end
    endtask

    task automatic test_clr();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; data_in = pk(16'(16'h70 + i)); step();
        end
        wr_en = 1'b0; rd_en = 1'b1; rd_hold = 1'b1; step();
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL clr_pre_valid got=%b want=1", rd_valid); end
        total++; if (count !== 5'd5)    begin bad++; $display("FAIL clr_pre_count got=%0d want=5", count); end
        clr = 1'b1; wr_en = 1'b1; rd_hold = 1'b0; data_in = pk(16'hEE); step();
        idle();
        total++; if (count !== 5'd0)    begin bad++; $display("FAIL clr_count got=%0d want=0", count); end
        total++; if (empty !== 1'b1)    begin bad++; $display("FAIL clr_empty got=%b want=1", empty); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL clr_valid got=%b want=0", rd_valid); end
        total++; if (data_out !== '0)   begin bad++; $display("FAIL clr_data got=%h want=0", data_out); end
        wr_en = 1'b1; data_in = pk(16'h77); step();
        wr_en = 1'b0; rd_en = 1'b1; step();
        rd_en = 1'b0;
        total++; if (data_out !== pk(16'h77)) begin bad++; $display("FAIL clr_after_data got=%h want=%h", data_out, pk(16'h77)); end
        total++; if (count !== 5'd0)          begin bad++; $display("FAIL clr_after_count got=%0d want=0", count); end
    endtask

`ifdef FIFO_ERR_FLAGS_EN
    task automatic test_err_flags();
        rd_en = 1'b1; step(); rd_en = 1'b0;
        total++; if (udf_err !== 1'b1) begin bad++; $display("FAIL udf_set got=%b want=1", udf_err); end
        step(); step();
        total++; if (udf_err !== 1'b1) begin bad++; $display("FAIL udf_sticky got=%b want=1", udf_err); end
        total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL ovf_quiet got=%b want=0", ovf_err); end
        clr = 1'b1; step(); clr = 1'b0;
        total++; if (udf_err !== 1'b0) begin bad++; $display("FAIL udf_clr got=%b want=0", udf_err); end
        for (int i = 0; i < 11; i++) begin
            wr_en = 1'b1; data_in = pk(16'(i)); step();
        end
        wr_en = 1'b0;
        total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", ovf_err); end
        clr = 1'b1; step(); clr = 1'b0;
        total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b want=0", ovf_err); end
    endtask
`endif

    initial begin
        rst     = 1'b1;
        idle();
        data_in = '0;
        #1;
        test_reset();
        test_fill_drain();
        test_wrap();
        test_empty_push_pop();
        test_full_simul();
        test_replay();
        test_clr();
`ifdef FIFO_ERR_FLAGS_EN
        test_err_flags();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
